// File: rtl/tribus_arbiter_if.sv
// Bus-side bundle for the tristate bus arbiter: per-channel requests and data in,
// one-hot grant, shared tristate data bus and busy flag out.
interface tribus_arbiter_if #(
    parameter int DATAWIDTH = 16,
    parameter int NCH       = 4
);
    logic [NCH-1:0]           req;
    logic [NCH*DATAWIDTH-1:0] din;
    logic [NCH-1:0]           gnt;
    wire  [DATAWIDTH-1:0]     dout;
    logic                     busy;

    modport master (output req, din, input gnt, dout, busy);
    modport slave  (input req, din, output gnt, dout, busy);
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for a shared tristate bus with hold-time preemption and
// a one-cycle high-Z turnaround between owners.
module tribus_lane #(
    parameter int DATAWIDTH = 16
) (
    input  logic                 sel,
    input  logic [DATAWIDTH-1:0] din,
    output logic [DATAWIDTH-1:0] dsel
);
    assign dsel = sel ? din : '0;
endmodule

module tribus_arbiter #(
    parameter int DATAWIDTH = 16,
    parameter int NCH       = 4,
    parameter int MAXHOLD   = 8
) (
    input logic            clk,
    input logic            reset,
    tribus_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;
    localparam logic [7:0] HOLDMAX = 8'(MAXHOLD - 1);
    localparam logic [NCH-1:0] ONE = NCH'(1);

    logic [1:0]     state;
    logic [NCH-1:0] gnt_q;
    logic [IW-1:0]  last_owner;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  idx;
    logic           found;
    logic [7:0]     hold;
    logic           any_req;
    logic           owner_req;
    logic           others;

    assign any_req   = |bus.req;
    assign owner_req = |(bus.req & gnt_q);
    assign others    = |(bus.req & ~gnt_q);

    // Search starts just past the last owner, so the released channel comes last.
    always_comb begin
        pick  = last_owner;
        idx   = last_owner;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = IW'((int'(last_owner) + k) % NCH);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_q      <= '0;
            last_owner <= IW'(NCH - 1);
            hold       <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (any_req) begin
                        state      <= DRIVE;
                        gnt_q      <= ONE << pick;
                        last_owner <= pick;
                        hold       <= '0;
                    end else begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end
                end
                DRIVE: begin
                    // Release and preemption share one exit, so both at once still give one TURN.
                    if (!owner_req || (hold == HOLDMAX && others)) begin
                        state <= TURN;
                        gnt_q <= '0;
                        hold  <= '0;
                    end else if (hold != HOLDMAX) begin
                        hold <= hold + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                    hold  <= '0;
                end
            endcase
        end
    end

    logic [NCH-1:0][DATAWIDTH-1:0] dsel;
    logic [DATAWIDTH-1:0]          dor;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        tribus_lane #(.DATAWIDTH(DATAWIDTH)) u_lane (
            .sel  (gnt_q[i]),
            .din  (bus.din[i*DATAWIDTH +: DATAWIDTH]),
            .dsel (dsel[i])
        );
    end

    always_comb begin
        dor = '0;
        for (int i = 0; i < NCH; i++) dor = dor | dsel[i];
    end

    // The grant register is cleared asynchronously, so the bus floats as soon as reset rises.
    assign bus.dout = (|gnt_q) ? dor : {DATAWIDTH{1'bz}};
    assign bus.gnt  = gnt_q;
    assign bus.busy = |gnt_q;
endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter: single request, preemption, sole-owner hold,
// async reset, round-robin with MAXHOLD=2, plus a per-cycle bus monitor.
module tb_tribus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   npass = 0;
    int   ntotal = 0;
    int   n;
    int   bad;

    always #5 clk = ~clk;

    tribus_arbiter_if #(.DATAWIDTH(16), .NCH(4)) b8 ();
    tribus_arbiter_if #(.DATAWIDTH(16), .NCH(4)) b2 ();

    tribus_arbiter #(.DATAWIDTH(16), .NCH(4), .MAXHOLD(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    tribus_arbiter #(.DATAWIDTH(16), .NCH(4), .MAXHOLD(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chkz(input string tag, input bit isz, input bit expz);
        ntotal++;
        assert (isz === expz) npass++;
        else $error("FAIL %s observed_highz=%0d expected_highz=%0d", tag, isz, expz);
    endtask

    // Bus monitor: at most one grant, and no drive on the bus without a grant.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("mon_onehot8", 32'($countones(b8.gnt) <= 1), 32'd1);
            chk("mon_onehot2", 32'($countones(b2.gnt) <= 1), 32'd1);
            chk("mon_float8", 32'((b8.gnt != 4'b0) || (b8.dout === 16'bz)), 32'd1);
            chk("mon_float2", 32'((b2.gnt != 4'b0) || (b2.dout === 16'bz)), 32'd1);
        end
    end

    logic [3:0]  rr_gnt [14];
    logic [15:0] rr_dat [14];

    initial begin
        rr_gnt = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                   4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
        rr_dat = '{16'h1111, 16'h1111, 16'h0, 16'h2222, 16'h2222, 16'h0, 16'h3333,
                   16'h3333, 16'h0, 16'h4444, 16'h4444, 16'h0, 16'h1111, 16'h1111};
        reset  = 1'b1;
        b8.req = '0;
        b8.din = {16'h3333, 16'h2222, 16'hBBBB, 16'hA5A5};
        b2.req = '0;
        b2.din = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        #2;
        chk("rst_gnt", 32'(b8.gnt), 32'h0);
        chk("rst_busy", 32'(b8.busy), 32'h0);
        chkz("rst_dout", b8.dout === 16'bz, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Single requester, then release through TURN into IDLE
        b8.req = 4'b0001;
        @(negedge clk);
        chk("single_gnt", 32'(b8.gnt), 32'h1);
        chk("single_dout", 32'(b8.dout), 32'hA5A5);
        chk("single_busy", 32'(b8.busy), 32'h1);
        b8.din[15:0] = 16'h1234;
        #1;
        chk("single_dout_comb", 32'(b8.dout), 32'h1234);
        b8.req = 4'b0000;
        @(negedge clk);
        chk("single_turn_gnt", 32'(b8.gnt), 32'h0);
        chk("single_turn_busy", 32'(b8.busy), 32'h0);
        chkz("single_turn_dout", b8.dout === 16'bz, 1'b1);
        @(negedge clk);
        chk("single_idle_gnt", 32'(b8.gnt), 32'h0);

        // Preemption: ch1 holds, ch2 joins after one cycle
        b8.req = 4'b0010;
        @(negedge clk);
        chk("pre_gnt1", 32'(b8.gnt), 32'h2);
        b8.req = 4'b0110;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b8.gnt == 4'b0010) n++;
            else break;
        end
        chk("pre_hold_cycles", 32'(n), 32'd8);
        chk("pre_turn_gnt", 32'(b8.gnt), 32'h0);
        chkz("pre_turn_dout", b8.dout === 16'bz, 1'b1);
        @(negedge clk);
        chk("pre_gnt2", 32'(b8.gnt), 32'h4);
        chk("pre_dout2", 32'(b8.dout), 32'h2222);

        // Async reset mid-DRIVE, between edges
        #2 reset = 1'b1;
        #1;
        chk("arst_gnt", 32'(b8.gnt), 32'h0);
        chk("arst_busy", 32'(b8.busy), 32'h0);
        chkz("arst_dout", b8.dout === 16'bz, 1'b1);
        #1 reset = 1'b0;
        b8.req = 4'b0100;
        @(negedge clk);
        chk("arst_regrant", 32'(b8.gnt), 32'h4);

        // Sole-owner hold for 300 cycles
        b8.req = 4'b0000;
        @(negedge clk);
        chk("sole_turn", 32'(b8.gnt), 32'h0);
        b8.req = 4'b0010;
        @(negedge clk);
        chk("sole_gnt", 32'(b8.gnt), 32'h2);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (b8.gnt !== 4'b0010) bad++;
        end
        chk("sole_hold_bad", 32'(bad), 32'd0);

        // Hold counter saturated: a new requester preempts at the next edge
        b8.req = 4'b0011;
        @(negedge clk);
        chk("sat_preempt_turn", 32'(b8.gnt), 32'h0);
        @(negedge clk);
        chk("sat_next_gnt", 32'(b8.gnt), 32'h1);

        // Owner drops in the same cycle preemption fires: a single TURN
        repeat (7) @(negedge clk);
        chk("both_last_cycle", 32'(b8.gnt), 32'h1);
        b8.req = 4'b0010;
        @(negedge clk);
        chk("both_turn", 32'(b8.gnt), 32'h0);
        @(negedge clk);
        chk("both_next_gnt", 32'(b8.gnt), 32'h2);
        b8.req = 4'b0000;
        @(negedge clk);
        chk("drain_turn", 32'(b8.gnt), 32'h0);
        @(negedge clk);
        chk("drain_idle", 32'(b8.gnt), 32'h0);

        // Round-robin, MAXHOLD=2, all channels requesting
        b2.req = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", i), 32'(b2.gnt), 32'(rr_gnt[i]));
            if (rr_gnt[i] != 4'b0000) chk($sformatf("rr_dout%0d", i), 32'(b2.dout), 32'(rr_dat[i]));
            else chkz($sformatf("rr_dz%0d", i), b2.dout === 16'bz, 1'b1);
        end
        b2.req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/tribus_arbiter.md
TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16, giving the width of each data channel and of the shared bus.
REQ-002 The block SHALL have parameter NCH, default 4, range 2..8, giving the number of requesting channels.
REQ-003 The block SHALL have parameter MAXHOLD, default 8, range 2..255, giving the cycles an owner may hold the bus while another channel waits.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous reset, active high.
REQ-007 Port req, input, NCH bits: per-channel bus request, level-sensitive.
REQ-008 Port din, input, NCH*DATAWIDTH bits: channel i data is on din[i*DATAWIDTH +: DATAWIDTH].
REQ-009 Port gnt, output, NCH bits: registered one-hot grant, or all zero.
REQ-010 Port dout, output (tristate), DATAWIDTH bits: shared bus, high-Z when no channel owns it.
REQ-011 Port busy, output, 1 bit: high when any bit of gnt is high.

Function
REQ-012 The state machine SHALL have three states: IDLE (no owner), DRIVE (one owner), and TURN (one dead cycle with the bus high-Z).
REQ-013 In IDLE with any req bit high at a rising edge, the block SHALL move to DRIVE and set gnt to the chosen channel at that edge.
REQ-014 Grant latency SHALL be one edge from a sampled req to gnt high; dout SHALL be valid in the same cycle that gnt is high.
REQ-015 In DRIVE, dout SHALL carry din of the owner combinationally, so that per-cycle changes of din pass straight to the bus.
REQ-016 The arbitration order SHALL be round-robin: search begins at last_owner+1 modulo NCH; last_owner resets to NCH-1, so the first search starts at channel 0.
REQ-017 In DRIVE, if the owner's req is low at an edge, the block SHALL move to TURN and clear gnt.
REQ-018 In DRIVE, the hold counter SHALL increment each cycle and saturate at MAXHOLD-1.
REQ-019 When the hold counter equals MAXHOLD-1, the owner's req is still high, and any other req is high, the block SHALL move to TURN (preemption).
REQ-020 If the owner's req is still high and no other req is high, the owner SHALL keep the bus indefinitely.
REQ-021 In TURN, gnt SHALL be zero and dout high-Z for exactly one cycle.
REQ-022 At the next edge out of TURN, the block SHALL arbitrate into DRIVE if any req is high, otherwise go to IDLE.
REQ-023 The just-released channel SHALL be eligible out of TURN only after all other requesters in round-robin order, or if it is the sole requester.
REQ-024 The hold counter SHALL clear on every entry to DRIVE.
REQ-025 gnt SHALL never have more than one bit set, and dout SHALL never be driven in IDLE or TURN.
REQ-026 Changes to req bits of non-owners during DRIVE SHALL affect only the preemption decision and the next arbitration.
REQ-027 An owner's req falling in the same cycle the preemption condition holds SHALL produce a single TURN cycle, not two.

Reset
REQ-028 Reset high SHALL immediately, without a clock, force IDLE, gnt=0, busy=0, dout high-Z, hold counter=0, and last_owner=NCH-1.
REQ-029 Reset asserted mid-DRIVE SHALL release the bus within the same cycle.
REQ-030 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset low.

Verification
REQ-031 Single requester: DATAWIDTH=16, NCH=4, req=0001, din0=16'hA5A5 -> one edge later gnt=0001, dout=A5A5, busy=1; drop req -> TURN cycle with dout=Z, then IDLE with gnt=0000.
REQ-032 Round-robin: req=1111 held, MAXHOLD=2 -> gnt sequence 0001, Z, 0010, Z, 0100, Z, 1000, Z, 0001, with each grant lasting 2 cycles.
REQ-033 Preemption: ch1 holds req, ch2 raises req after 1 cycle, MAXHOLD=8 -> ch1 gnt lasts 8 cycles, one TURN cycle follows, then gnt=0100.
REQ-034 Sole-owner hold: req=0010 for 300 cycles -> gnt=0010 for all cycles, with no TURN.
REQ-035 Async reset mid-DRIVE: reset pulsed between clock edges while gnt=0100 -> gnt=0000 and dout=Z before the next edge; req=0100 after release -> gnt=0100 one edge later.
REQ-036 Turnaround check: a bus monitor on every cycle -> dout is never driven while gnt=0, and popcount(gnt)<=1 throughout.
